// File: rtl/asic_lock_seq_tx.sv
// ============================================================================
// asic_lock_seq_tx : issues the &BCxx lock/unlock write sequence over req/ack
// Revision: 1.0
// ============================================================================
`default_nettype none

module asic_lock_seq_tx #(
    parameter int PATENT_BEHAVIOUR = 0,
    parameter int GAP              = 1
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       start,
    input  logic       lock,
    input  logic       abort,
    input  logic       wr_ack,
    output logic       wr_req,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       done
);

    // Index of the last PRBS byte in SEQ; the trigger position shifts by one with the patent option.
    localparam logic [3:0] C_UNLOCK_LAST = (PATENT_BEHAVIOUR != 0) ? 4'd14 : 4'd13;
    localparam logic [3:0] C_LOCK_LAST   = (PATENT_BEHAVIOUR != 0) ? 4'd13 : 4'd12;
    localparam logic [3:0] C_GAP_INIT    = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam logic [7:0] C_LOCK_TERM   = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SYNC_FF  = 3'd1,
        ST_SYNC_00  = 3'd2,
        ST_SEQ      = 3'd3,
        ST_TERM     = 3'd4,
        ST_GAP_WAIT = 3'd5
    } state_t;

    state_t     r_state;
    state_t     r_resume_state;
    logic       r_mode;
    logic [7:0] r_prbs;
    logic [3:0] r_idx;
    logic [3:0] r_gap_cnt;

    logic [7:0] w_prbs_step;
    logic       w_seq_last;
    state_t     w_after_state;
    logic [7:0] w_after_data;

    assign w_prbs_step = {r_prbs[7] ^ r_prbs[4], r_prbs[7], r_prbs[6], r_prbs[5],
                          r_prbs[1] ^ r_prbs[0], r_prbs[3], r_prbs[2], r_prbs[1]};
    assign w_seq_last  = (r_idx == (r_mode ? C_LOCK_LAST : C_UNLOCK_LAST));

    // State and byte that follow an accepted byte in the current state.
    always_comb begin
        w_after_state = ST_IDLE;
        w_after_data  = 8'h00;
        case (r_state)
            ST_SYNC_FF: begin
                w_after_state = ST_SYNC_00;
                w_after_data  = 8'h00;
            end
            ST_SYNC_00: begin
                w_after_state = ST_SEQ;
                w_after_data  = r_prbs;
            end
            ST_SEQ: begin
                if (w_seq_last) begin
                    w_after_state = ST_TERM;
                    w_after_data  = r_mode ? C_LOCK_TERM : w_prbs_step;
                end else begin
                    w_after_state = ST_SEQ;
                    w_after_data  = w_prbs_step;
                end
            end
            default: begin
                w_after_state = ST_IDLE;
                w_after_data  = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state        <= ST_IDLE;
            r_resume_state <= ST_IDLE;
            r_mode         <= 1'b0;
            r_prbs         <= 8'hFF;
            r_idx          <= 4'd0;
            r_gap_cnt      <= 4'd0;
            wr_req         <= 1'b0;
            wr_data        <= 8'h00;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (start) begin
                    r_mode  <= lock;
                    r_prbs  <= 8'hFF;
                    r_idx   <= 4'd0;
                    busy    <= 1'b1;
                    wr_req  <= 1'b1;
                    wr_data <= 8'hFF;
                    r_state <= ST_SYNC_FF;
                end
            end else if (abort) begin
                r_state <= ST_IDLE;
                wr_req  <= 1'b0;
                busy    <= 1'b0;
            end else if (r_state == ST_GAP_WAIT) begin
                if (r_gap_cnt == 4'd0) begin
                    r_state <= r_resume_state;
                    wr_req  <= 1'b1;
                end else begin
                    r_gap_cnt <= r_gap_cnt - 4'd1;
                end
            end else if (wr_ack) begin
                if (r_state == ST_TERM) begin
                    r_state <= ST_IDLE;
                    wr_req  <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end else begin
                    if (r_state == ST_SEQ) begin
                        r_prbs <= w_prbs_step;
                        r_idx  <= r_idx + 4'd1;
                    end
                    // The next byte is loaded now; during a gap it simply waits with wr_req low.
                    wr_data <= w_after_data;
                    if (GAP == 0) begin
                        r_state <= w_after_state;
                    end else begin
                        r_state        <= ST_GAP_WAIT;
                        r_resume_state <= w_after_state;
                        r_gap_cnt      <= C_GAP_INIT;
                        wr_req         <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_asic_lock_seq_tx.sv
// ============================================================================
// tb_asic_lock_seq_tx : directed checks of the lock/unlock write sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_asic_lock_seq_tx;

    localparam logic [7:0] PRBS_RUN [16] = '{8'hff, 8'h77, 8'hb3, 8'h51, 8'ha8, 8'hd4, 8'h62, 8'h39,
                                             8'h9c, 8'h46, 8'h2b, 8'h15, 8'h8a, 8'hcd, 8'hee, 8'hff};

    logic       clk = 1'b0;
    logic       reset_b;
    logic       lock;
    logic       abort;
    logic       wr_ack;
    logic [2:0] start_v;
    logic [2:0] req_v;
    logic [2:0] bsy_v;
    logic [2:0] dn_v;
    logic [7:0] data0, data1, data2;

    logic [1:0] sel;
    logic       c_req, c_busy, c_done;
    logic [7:0] c_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // dut0: emulator timing, one idle cycle; dut1: patent timing; dut2: back-to-back bytes
    asic_lock_seq_tx #(.PATENT_BEHAVIOUR(0), .GAP(1)) dut0 (
        .clk(clk), .reset_b(reset_b), .start(start_v[0]), .lock(lock), .abort(abort),
        .wr_ack(wr_ack), .wr_req(req_v[0]), .wr_data(data0), .busy(bsy_v[0]), .done(dn_v[0]));
    asic_lock_seq_tx #(.PATENT_BEHAVIOUR(1), .GAP(1)) dut1 (
        .clk(clk), .reset_b(reset_b), .start(start_v[1]), .lock(lock), .abort(abort),
        .wr_ack(wr_ack), .wr_req(req_v[1]), .wr_data(data1), .busy(bsy_v[1]), .done(dn_v[1]));
    asic_lock_seq_tx #(.PATENT_BEHAVIOUR(0), .GAP(0)) dut2 (
        .clk(clk), .reset_b(reset_b), .start(start_v[2]), .lock(lock), .abort(abort),
        .wr_ack(wr_ack), .wr_req(req_v[2]), .wr_data(data2), .busy(bsy_v[2]), .done(dn_v[2]));

    always_comb begin
        c_req  = req_v[sel];
        c_busy = bsy_v[sel];
        c_done = dn_v[sel];
        case (sel)
            2'd0:    c_data = data0;
            2'd1:    c_data = data1;
            default: c_data = data2;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int nb, input int total, input logic [7:0] term);
        if (nb == 0)          return 8'hFF;
        else if (nb == 1)     return 8'h00;
        else if (nb == total - 1) return term;
        else                  return PRBS_RUN[nb - 2];
    endfunction

    task automatic check_reset_all(input string tag);
        for (int d = 0; d < 3; d++) begin
            sel = 2'(d);
            #0;
            check({tag, " wr_req"},  {31'd0, c_req},  32'd0);
            check({tag, " wr_data"}, {24'd0, c_data}, 32'd0);
            check({tag, " busy"},    {31'd0, c_busy}, 32'd0);
            check({tag, " done"},    {31'd0, c_done}, 32'd0);
        end
    endtask

    // Runs one full sequence on DUT d and checks every transferred byte, timing and done.
    task automatic run_seq(input int d, input logic lk, input int total, input logic [7:0] term,
                           input int exp_lat, input int stall_byte, input int stall_len,
                           input string tag);
        int  nb = 0;
        int  cyc = 1;
        int  stalled = 0;
        int  req_cycles = 0;
        bit  got_done = 0;
        @(negedge clk);
        sel    = 2'(d);
        lock   = lk;
        wr_ack = 1'b1;
        start_v[d] = 1'b1;
        @(posedge clk);
        #1;
        start_v = '0;
        while (!got_done && cyc < 200) begin
            start_v = '0;
            if (c_done) begin
                got_done = 1;
                check({tag, " latency"},    cyc,           exp_lat);
                check({tag, " byte count"}, nb,            total);
                check({tag, " req cycles"}, req_cycles,    total + stall_len);
                check({tag, " busy at done"}, {31'd0, c_busy}, 32'd0);
                check({tag, " req at done"},  {31'd0, c_req},  32'd0);
            end else begin
                if (c_busy !== 1'b1)
                    check({tag, " busy held"}, {31'd0, c_busy}, 32'd1);
                if (c_req) begin
                    req_cycles++;
                    if (nb == stall_byte && stalled < stall_len) begin
                        check($sformatf("%s hold byte%0d", tag, nb), {24'd0, c_data},
                              {24'd0, exp_byte(nb, total, term)});
                        wr_ack = 1'b0;
                        if (stalled == 1) begin
                            start_v[d] = 1'b1;
                            lock = ~lk;
                        end
                        stalled++;
                    end else begin
                        check($sformatf("%s byte%0d", tag, nb), {24'd0, c_data},
                              {24'd0, exp_byte(nb, total, term)});
                        wr_ack = 1'b1;
                        nb++;
                    end
                end
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        if (!got_done)
            check({tag, " done timeout"}, 32'd0, 32'd1);
        wr_ack = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " done one cycle"}, {31'd0, c_done}, 32'd0);
    endtask

    initial begin
        int n;
        reset_b = 1'b0;
        lock    = 1'b0;
        abort   = 1'b0;
        wr_ack  = 1'b1;
        start_v = '0;
        sel     = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_all("reset");
        @(negedge clk);
        reset_b = 1'b1;
        @(posedge clk);
        #1;

        run_seq(0, 1'b0, 17, 8'hee, 34, -1, 0, "unlock_p0");
        run_seq(0, 1'b1, 16, 8'ha5, 32, -1, 0, "lock_p0");
        run_seq(1, 1'b1, 17, 8'ha5, 34, -1, 0, "lock_p1");
        run_seq(1, 1'b0, 18, 8'hff, 36, -1, 0, "unlock_p1");
        run_seq(0, 1'b0, 17, 8'hee, 39, 2, 5, "stall");

        // Abort while 0x51 is offered, with wr_ack also high in that cycle.
        @(negedge clk);
        sel = 2'd0;
        lock = 1'b0;
        wr_ack = 1'b1;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v = '0;
        n = 0;
        while (!(c_req && c_data == 8'h51) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("abort reach 0x51", {31'd0, (n < 100)}, 32'd1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort wr_req", {31'd0, c_req},  32'd0);
        check("abort busy",   {31'd0, c_busy}, 32'd0);
        check("abort done",   {31'd0, c_done}, 32'd0);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (c_done || c_req) n++;
        end
        check("abort stays idle", n, 0);
        run_seq(0, 1'b0, 17, 8'hee, 34, -1, 0, "restart");

        // start and abort together in IDLE: start wins.
        @(negedge clk);
        sel = 2'd2;
        lock = 1'b0;
        abort = 1'b1;
        start_v[2] = 1'b1;
        @(posedge clk);
        #1;
        start_v = '0;
        check("start+abort busy",    {31'd0, c_busy}, 32'd1);
        check("start+abort wr_req",  {31'd0, c_req},  32'd1);
        check("start+abort wr_data", {24'd0, c_data}, 32'hff);
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort over ack wr_req", {31'd0, c_req},  32'd0);
        check("abort over ack busy",   {31'd0, c_busy}, 32'd0);
        check("abort over ack done",   {31'd0, c_done}, 32'd0);

        // Asynchronous reset in the middle of SEQ.
        @(negedge clk);
        sel = 2'd0;
        lock = 1'b0;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v = '0;
        repeat (10) @(posedge clk);
        #2;
        check("mid-seq busy before reset", {31'd0, c_busy}, 32'd1);
        reset_b = 1'b0;
        #1;
        check_reset_all("async reset");
        @(negedge clk);
        reset_b = 1'b1;
        @(posedge clk);
        #1;
        sel = 2'd0;
        #0;
        check("post reset busy", {31'd0, c_busy}, 32'd0);

        run_seq(2, 1'b0, 17, 8'hee, 18, -1, 0, "gap0");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
